// File: rtl/sh7604_dbus_arb.sv
// SH7604 data-bus arbiter: muxes CPU and DMAC masters onto one BSC port.
// Optional CPU fairness window enabled by macro SH7604_DBUS_ARB_FAIR_EN.
module sh7604_dbus_arb #(
  parameter int DMA_SLOTS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_r,
  input  logic        ce_f,
  input  logic [31:0] cpu_a,
  input  logic [31:0] cpu_do,
  input  logic [3:0]  cpu_ba,
  input  logic        cpu_we,
  input  logic        cpu_req,
  input  logic        cpu_lock,
  output logic [31:0] cpu_di,
  output logic        cpu_wait,
  input  logic [31:0] dma_a,
  input  logic [31:0] dma_do,
  input  logic [3:0]  dma_ba,
  input  logic        dma_we,
  input  logic        dma_req,
  input  logic        dma_lock,
  input  logic        dma_burst,
  output logic [31:0] dma_di,
  output logic        dma_wait,
  output logic [31:0] bus_a,
  output logic [31:0] bus_do,
  output logic [3:0]  bus_ba,
  output logic        bus_we,
  output logic        bus_req,
  output logic        bus_burst,
  input  logic [31:0] bus_di,
  input  logic        bus_wait,
  output logic [1:0]  owner
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CPU  = 2'b01,
    S_DMA  = 2'b10
  } state_t;

  if (DMA_SLOTS < 1) begin : g_bad_slots
    $error("DMA_SLOTS must be at least 1");
  end

  state_t state, state_n, pick;
  logic   owner_req, owner_lock, owner_burst, hold;
  logic   xfer_done, release_ok, done_free, cpu_force;

  always_comb begin
    owner_req   = 1'b0;
    owner_lock  = 1'b0;
    owner_burst = 1'b0;
    case (state)
      S_CPU: begin
        owner_req  = cpu_req;
        owner_lock = cpu_lock;
      end
      S_DMA: begin
        owner_req   = dma_req;
        owner_lock  = dma_lock;
        owner_burst = dma_burst;
      end
      default: ;
    endcase
  end

  assign hold      = owner_lock | owner_burst;
  assign xfer_done = ce_f & owner_req & ~bus_wait;
  // done_free remembers that the most recent completion ended an unlocked, non-burst transfer
  assign release_ok = (state == S_IDLE) | (~hold & (~owner_req | done_free));

`ifdef SH7604_DBUS_ARB_FAIR_EN
  localparam int CW = $clog2(DMA_SLOTS + 1);
  localparam logic [CW-1:0] SLOTS = CW'(DMA_SLOTS);
  logic [CW-1:0] fair_cnt;

  assign cpu_force = (fair_cnt == SLOTS);

  always_ff @(posedge clk) begin
    if (rst)
      fair_cnt <= '0;
    else if (ce_r && release_ok && pick == S_CPU)
      fair_cnt <= '0;
    else if (xfer_done && state == S_DMA && !hold && cpu_req && fair_cnt != SLOTS)
      fair_cnt <= fair_cnt + 1'b1;
  end
`else
  assign cpu_force = 1'b0;
`endif

  always_comb begin
    pick = S_IDLE;
    if (dma_req && !(cpu_force && cpu_req))
      pick = S_DMA;
    else if (cpu_req)
      pick = S_CPU;
  end

  always_comb begin
    state_n = state;
    if (ce_r && release_ok)
      state_n = pick;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      done_free <= 1'b0;
    end else begin
      state <= state_n;
      if (ce_r && release_ok)
        done_free <= 1'b0;
      else if (xfer_done)
        done_free <= ~hold;
    end
  end

  always_comb begin
    bus_a     = '0;
    bus_do    = '0;
    bus_ba    = '0;
    bus_we    = 1'b0;
    bus_req   = 1'b0;
    bus_burst = 1'b0;
    cpu_wait  = cpu_req;
    dma_wait  = dma_req;
    case (state)
      S_CPU: begin
        bus_a    = cpu_a;
        bus_do   = cpu_do;
        bus_ba   = cpu_ba;
        bus_we   = cpu_we;
        bus_req  = cpu_req;
        cpu_wait = bus_wait;
      end
      S_DMA: begin
        bus_a     = dma_a;
        bus_do    = dma_do;
        bus_ba    = dma_ba;
        bus_we    = dma_we;
        bus_req   = dma_req;
        bus_burst = dma_burst;
        dma_wait  = bus_wait;
      end
      default: ;
    endcase
  end

  assign cpu_di = bus_di;
  assign dma_di = bus_di;
  assign owner  = state;

endmodule

// File: doc/sh7604_dbus_arb.md
SH7604_DBUS_ARB -- requirements
Module: sh7604_dbus_arb

Interface
REQ-001 Parameter: DMA_SLOTS, default 4, max consecutive unlocked DMAC transfers before a pending CPU request must be granted (used only with SH7604_DBUS_ARB_FAIR_EN).
REQ-002 CLK  in  1  system clock; single clock domain.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 CE_R  in  1  rising-phase clock enable; all grant decisions are made on it.
REQ-005 CE_F  in  1  falling-phase clock enable; transfer completion is sampled on it.
REQ-006 CPU_A / CPU_DO  in  32 each  CPU address / write data.
REQ-007 CPU_BA  in  4  CPU byte enables.
REQ-008 CPU_WE, CPU_REQ, CPU_LOCK  in  1 each  CPU write, request, locked sequence (TAS).
REQ-009 CPU_DI  out  32  read data to CPU.
REQ-010 CPU_WAIT  out  1  CPU stall.
REQ-011 DMA_A / DMA_DO  in  32 each  DMAC address / write data.
REQ-012 DMA_BA  in  4  DMAC byte enables.
REQ-013 DMA_WE, DMA_REQ, DMA_LOCK, DMA_BURST  in  1 each  DMAC write, request, lock, burst.
REQ-014 DMA_DI  out  32  read data to DMAC.
REQ-015 DMA_WAIT  out  1  DMAC stall.
REQ-016 BUS_A / BUS_DO  out  32 each  address / write data to BSC.
REQ-017 BUS_BA  out  4  byte enables to BSC.
REQ-018 BUS_WE, BUS_REQ, BUS_BURST  out  1 each  write, request, burst to BSC.
REQ-019 BUS_DI  in  32  read data from BSC.
REQ-020 BUS_WAIT  in  1  BSC stall.
REQ-021 OWNER  out  2  00 idle, 01 CPU, 10 DMAC.

Function
REQ-022 Registered FSM, states IDLE, CPU, DMA; OWNER mirrors state.
REQ-023 IDLE, CE_R: DMA_REQ -> DMA; else CPU_REQ -> CPU; else stay. DMAC wins simultaneous requests.
REQ-024 A transfer completes on a CE_F cycle where owner REQ=1 and BUS_WAIT=0.
REQ-025 Owner releases only at a CE_R cycle where owner REQ=0, or its last transfer completed with LOCK=0 (and BURST=0 for DMAC); release goes IDLE-equivalent and re-arbitrates in the same CE_R (direct CPU<->DMA handover allowed).
REQ-026 While owner LOCK=1 or DMA_BURST=1, no handover, regardless of other requests.
REQ-027 BUS_* outputs combinationally muxed from owner's inputs; in IDLE, BUS_REQ=0, BUS_A/BUS_DO=0, BUS_BA=0, BUS_WE=0, BUS_BURST=0.
REQ-028 Owner's WAIT = BUS_WAIT; non-owner WAIT = its REQ; in IDLE, WAIT = REQ for both.
REQ-029 CPU_DI and DMA_DI both carry BUS_DI unconditionally; masters qualify by WAIT.
REQ-030 Grant latency: request asserted before a CE_R in IDLE -> OWNER valid on next CLK; BUS_REQ follows same cycle.
REQ-031 Owner REQ dropping mid-transfer (WAIT=1) is legal; next CE_R releases.

Reset
REQ-032 RST (sync, any cycle incl. mid-transfer): state IDLE, OWNER=00, fairness counter 0; outputs per REQ-027/028 on next CLK.
REQ-033 RST overrides CE_R/CE_F.

Configuration
REQ-034 Macro SH7604_DBUS_ARB_FAIR_EN defined: counter (width clog2(DMA_SLOTS+1)) counts completed unlocked, non-burst DMAC transfers while CPU_REQ=1; at DMA_SLOTS, next release point hands bus to CPU even if DMA_REQ=1; counter clears on CPU grant.
REQ-035 Macro undefined: no counter; DMAC strict priority per REQ-023/025; DMA_SLOTS unused.

Verification
REQ-036 RST=1 one CLK with both REQ=1 -> OWNER=00, BUS_REQ=0, CPU_WAIT=DMA_WAIT=1.
REQ-037 CPU_REQ=1, DMA_REQ=1 in IDLE, CE_R -> OWNER=10, BUS_A=DMA_A, CPU_WAIT=1.
REQ-038 CPU owns with CPU_LOCK=1, DMA_REQ rises -> OWNER stays 01 until CPU_LOCK=0 and completion, then 10.
REQ-039 DMA_BURST=1 four transfers, CPU_REQ=1 -> no handover until burst ends; BUS_BURST=1 throughout.
REQ-040 FAIR_EN, DMA_SLOTS=4, both REQ held, single DMAC transfers -> CPU granted after 4th DMAC completion; without macro CPU never granted.
REQ-041 RST asserted while BUS_WAIT=1 mid DMAC write -> next CLK OWNER=00, BUS_REQ=0.
